seq_multiplier: RTL and testbench

Iterative shift-add multiplier, parametrised in operand width, with per-operation signed/unsigned mode and valid/ready handshakes on input and output. It produces the full 2*WIDTH-bit product in WIDTH+1 cycles using a single adder. It replaces the single-cycle combinational `multiplier` wherever area matters more than throughput, and sits between any producer and consumer that use the team's valid/ready convention.

---
 rtl/seq_multiplier.sv | 111 +++++++++++
 tb/tb_seq_multiplier.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one adder, WIDTH busy
// cycles per product, signed/unsigned per operation, valid/ready both sides.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_sign;
  // upper half accumulates partial sums; lower half starts as the
  // multiplier magnitude and is consumed one bit per shift
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_out;
  logic [CW-1:0]      r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_sign;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;

  // magnitudes at capture; the most negative value maps to 2^(WIDTH-1)
  always_comb begin
    w_mag_a = ina;
    w_mag_b = inb;
    if (is_signed && ina[WIDTH-1]) w_mag_a = -ina;
    if (is_signed && inb[WIDTH-1]) w_mag_b = -inb;
    w_sign = is_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
  end

  // one conditional add into the upper half, carry kept, then shift right
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_acc[0]) w_sum = w_sum + {1'b0, r_mcand};
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    w_prod = r_sign ? -w_acc_nxt : w_acc_nxt;
  end

  // control FSM with registered handshake outputs and product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_sign      <= 1'b0;
      r_acc       <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand    <= w_mag_a;
            r_acc      <= {{WIDTH{1'b0}}, w_mag_b};
            r_sign     <= w_sign;
            r_cnt      <= CW'(WIDTH);
            r_state    <= S_BUSY;
            r_in_ready <= 1'b0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_out       <= w_prod;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and randomised checks of seq_multiplier
// at WIDTH=16 and WIDTH=8, with a per-instance scoreboard.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(logic [15:0] a, logic [15:0] b,
                                          logic s, int w);
    longint sa;
    longint sb;
    longint p;
    logic [63:0] m;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & m;
  endfunction

  logic        rst;
  logic        iv[2];
  logic        ir[2];
  logic [15:0] a[2];
  logic [15:0] b[2];
  logic        sg[2];
  logic        ov[2];
  logic        ordy[2];
  logic [31:0] o[2];
  int          n_out[2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 16 : 8;
    logic             w_ir;
    logic             w_ov;
    logic [2*W-1:0]   w_o;
    logic [63:0]      q_e[$];
    int               q_t[$];
    logic             ov_q = 1'b0;

    seq_multiplier #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[gi]),
      .in_ready  (w_ir),
      .ina       (a[gi][W-1:0]),
      .inb       (b[gi][W-1:0]),
      .is_signed (sg[gi]),
      .out_valid (w_ov),
      .out_ready (ordy[gi]),
      .out       (w_o)
    );

    assign ir[gi] = w_ir;
    assign ov[gi] = w_ov;
    assign o[gi]  = 32'(w_o);

    always @(negedge clk) begin
      if (rst) begin
        q_e.delete();
        q_t.delete();
      end else begin
        if (ov[gi] && !ov_q) begin
          if (q_t.size() == 0) chk("spurious_valid", 1, 0);
          else chk("latency", 64'(cyc - q_t[0]), W);
        end
        if (ov[gi] && ordy[gi]) begin
          if (q_e.size() == 0) begin
            chk("dup_output", 1, 0);
          end else begin
            chk("product", o[gi], q_e.pop_front());
            void'(q_t.pop_front());
            n_out[gi]++;
          end
        end
        if (iv[gi] && ir[gi]) begin
          q_e.push_back(ref_mul(a[gi], b[gi], sg[gi], W));
          q_t.push_back(cyc + 1);
        end
      end
      ov_q = ov[gi];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op16(logic [15:0] x, logic [15:0] y, logic s,
                      logic [31:0] exp, string tag);
    int k;
    k = 0;
    while (!ir[0] && k < 50) begin
      tick();
      k++;
    end
    if (!ir[0]) chk({tag, "_ready_to"}, 0, 1);
    a[0]  = x;
    b[0]  = y;
    sg[0] = s;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    a[0]  = ~x;
    b[0]  = ~y;
    sg[0] = ~s;
    k = 0;
    while (!ov[0] && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 16);
    chk(tag, o[0], exp);
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
  endtask

  function automatic logic [15:0] rnd_op(int w);
    logic [15:0] m;
    logic [15:0] v;
    m = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = m;
      2:       v = 16'(32'd1 << (w - 1));
      3:       v = 16'd1;
      default: v = 16'($urandom);
    endcase
    return v & m;
  endfunction

  task automatic rand_run(int idx, int w, int n);
    int  sent;
    int  cycles;
    int  base;
    bit  hs;
    sent   = 0;
    cycles = 0;
    base   = n_out[idx];
    while (sent < n && cycles < 60000) begin
      hs = iv[idx] && ir[idx];
      tick();
      cycles++;
      if (hs) sent++;
      iv[idx]   = (sent < n) && ($urandom_range(0, 2) != 0);
      a[idx]    = rnd_op(w);
      b[idx]    = rnd_op(w);
      sg[idx]   = 1'($urandom_range(0, 1));
      ordy[idx] = ($urandom_range(0, 3) != 0);
    end
    iv[idx]   = 1'b0;
    ordy[idx] = 1'b1;
    chk("rand_sent", 64'(sent), 64'(n));
    cycles = 0;
    while (n_out[idx] - base < n && cycles < 200) begin
      tick();
      cycles++;
    end
    chk("rand_done", 64'(n_out[idx] - base), 64'(n));
    ordy[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i]    = 1'b0;
      a[i]     = '0;
      b[i]     = '0;
      sg[i]    = 1'b0;
      ordy[i]  = 1'b0;
      n_out[i] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", ir[i], 1);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_out", o[i], 0);
    end

    op16(16'd1234, 16'd5678, 1'b0, 32'd7006652, "u_basic");
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_max");
    op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_minmin");
    op16(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "s_min1");
    op16(16'h0000, 16'hFFFF, 1'b1, 32'h00000000, "s_zero");
    op16(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, "s_mixed");
    op16(16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, "u_mixed");

    a[0]  = 16'd3;
    b[0]  = 16'd5;
    sg[0] = 1'b0;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    for (int k = 0; k < 40 && !ov[0]; k++) tick();
    for (int k = 0; k < 10; k++) begin
      iv[0] = 1'b1;
      a[0]  = 16'd9;
      b[0]  = 16'd9;
      tick();
      chk("bp_valid", ov[0], 1);
      chk("bp_out", o[0], 32'd15);
      chk("bp_ready", ir[0], 0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("bp_release_valid", ov[0], 0);
    chk("bp_release_ready", ir[0], 1);
    tick();
    chk("bp_no_capture", ir[0], 1);

    a[0]  = 16'h1111;
    b[0]  = 16'h2222;
    sg[0] = 1'b0;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_out", o[0], 0);
    chk("mid_rst_ready", ir[0], 1);
    op16(16'd100, 16'd200, 1'b0, 32'd20000, "after_rst");

    fork
      rand_run(0, 16, 1000);
      rand_run(1, 8, 1000);
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
